ita_activation: RTL and testbench

- N-lane pipelined activation unit for the ITA accelerator, sitting after the requantizer of the feed-forward matmul output.
- Each cycle it applies Identity, ReLU or integer GELU to N signed 8-bit values.
- GELU is the I-BERT polynomial, followed by a requantization back to 8 bits.
- Fixed 4-cycle latency for all activation modes; one vector accepted per cycle.

---
 rtl/ita_activation.sv | 115 +++++++++++
 tb/tb_ita_activation.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ita_activation.sv
// ita_activation: N-lane, 4-stage activation unit (Identity / ReLU / I-BERT GELU with 8-bit requant).
// The activation select rides the pipeline with its data. Constants are sampled by the stage that uses them.
module ita_activation #(
    parameter int unsigned N                    = 16,
    parameter int unsigned WI                   = 8,
    parameter int unsigned GELU_CONSTANTS_WIDTH = 16,
    parameter int unsigned EMS                  = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [GELU_CONSTANTS_WIDTH-1:0] one_i,
    input  logic [GELU_CONSTANTS_WIDTH-1:0] b_i,
    input  logic [GELU_CONSTANTS_WIDTH-1:0] c_i,
    input  logic [N*WI-1:0]                 data_i,
    input  logic [1:0]                      activation_i,
    input  logic                            requant_mode_i,
    input  logic [EMS-1:0]                  requant_mult_i,
    input  logic [EMS-1:0]                  requant_shift_i,
    input  logic [EMS-1:0]                  requant_add_i,
    input  logic                            calc_en_i,
    input  logic                            calc_en_q_i,
    output logic [N*WI-1:0]                 data_o
);
    localparam int unsigned W  = 48;
    localparam int unsigned CW = GELU_CONSTANTS_WIDTH;
    localparam logic [1:0] IDENTITY = 2'd0, GELU = 2'd1, RELU = 2'd2;
    typedef logic signed [W-1:0] wide_t;
    localparam wide_t SMAX = wide_t'((1 << (WI - 1)) - 1);
    localparam wide_t SMIN = -SMAX - wide_t'(1);
    localparam wide_t UMAX = wide_t'((1 << WI) - 1);

    wide_t one_w, b_w, c_w, add_w, mult_w;
    logic [1:0] act1_q, act2_q, act3_q;

    assign one_w  = {{(W-CW){one_i[CW-1]}}, one_i};
    assign b_w    = {{(W-CW){b_i[CW-1]}}, b_i};
    assign c_w    = {{(W-CW){c_i[CW-1]}}, c_i};
    assign add_w  = {{(W-EMS){requant_add_i[EMS-1]}}, requant_add_i};
    assign mult_w = {{(W-EMS){1'b0}}, requant_mult_i};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act1_q <= IDENTITY;
            act2_q <= IDENTITY;
            act3_q <= IDENTITY;
        end else begin
            if (calc_en_i) begin
                act1_q <= activation_i;
                act2_q <= act1_q;
            end
            if (calc_en_q_i) act3_q <= act2_q;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WI-1:0] q1_q, q1_d, q2_q, res1_q, res1_d, res2_q, res3_q, out_q, out_d, gel;
        logic          s1_q, s1_d;
        wide_t         t1_q, t1_d, ql2_q, ql2_d, g3_q, g3_d;
        wide_t         qe, aq, a, l, p, pr, r, v;

        always_comb begin
            q1_d   = data_i[i*WI +: WI];
            qe     = {{(W-WI){q1_d[WI-1]}}, q1_d};
            aq     = qe[W-1] ? -qe : qe;
            a      = (aq < -b_w) ? aq : -b_w;
            s1_d   = qe[W-1];
            t1_d   = a + b_w;
            res1_d = (activation_i == RELU && qe[W-1]) ? '0 : q1_d;
            l      = t1_q * t1_q + c_w;
            ql2_d  = s1_q ? -l : l;
            g3_d   = $signed({{(W-WI){q2_q[WI-1]}}, q2_q}) * (ql2_q + one_w);
            p      = g3_q * mult_w;
            // Shift by one less, then use the last bit shifted out as the round-half-up carry
            pr     = p >>> (requant_shift_i - EMS'(1));
            r      = (requant_shift_i == '0) ? p : (pr >>> 1) + $signed({{(W-1){1'b0}}, pr[0]});
            v      = r + add_w;
            gel    = requant_mode_i
                   ? (v[W-1] ? '0 : (v > UMAX ? UMAX[WI-1:0] : v[WI-1:0]))
                   : (v < SMIN ? SMIN[WI-1:0] : (v > SMAX ? SMAX[WI-1:0] : v[WI-1:0]));
            out_d  = (act3_q == GELU) ? gel : res3_q;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                q1_q   <= '0;
                s1_q   <= 1'b0;
                t1_q   <= '0;
                res1_q <= '0;
                q2_q   <= '0;
                ql2_q  <= '0;
                res2_q <= '0;
                g3_q   <= '0;
                res3_q <= '0;
                out_q  <= '0;
            end else begin
                if (calc_en_i) begin
                    q1_q   <= q1_d;
                    s1_q   <= s1_d;
                    t1_q   <= t1_d;
                    res1_q <= res1_d;
                    q2_q   <= q1_q;
                    ql2_q  <= ql2_d;
                    res2_q <= res1_q;
                end
                if (calc_en_q_i) begin
                    g3_q   <= g3_d;
                    res3_q <= res2_q;
                    out_q  <= out_d;
                end
            end
        end

        assign data_o[i*WI +: WI] = out_q;
    end
endmodule

// File: tb/tb_ita_activation.sv
// tb_ita_activation: directed vector table plus hand-written reset, streaming and stall sequences.
module tb_ita_activation;
    localparam int N = 16, WI = 8;

    logic            clk = 1'b0, rst_ni = 1'b1;
    logic [15:0]     one_i = 16'd50, b_i = 16'hffec, c_i = 16'hff9c;
    logic [N*WI-1:0] data_i = '0, data_o;
    logic [1:0]      activation_i = 2'd0;
    logic            requant_mode_i = 1'b0, calc_en_i = 1'b1, calc_en_q_i = 1'b1;
    logic [7:0]      requant_mult_i = 8'd1, requant_shift_i = 8'd2, requant_add_i = 8'd0;

    int tests = 0, fails = 0;

    typedef struct {
        logic [1:0] act;
        logic       mode;
        logic [7:0] mult;
        logic [7:0] shift;
        logic [7:0] add;
        byte        q;
        byte        exp;
    } vec_t;
    vec_t tbl[$];

    ita_activation dut (
        .clk_i(clk), .rst_ni(rst_ni), .one_i(one_i), .b_i(b_i), .c_i(c_i),
        .data_i(data_i), .activation_i(activation_i), .requant_mode_i(requant_mode_i),
        .requant_mult_i(requant_mult_i), .requant_shift_i(requant_shift_i),
        .requant_add_i(requant_add_i), .calc_en_i(calc_en_i), .calc_en_q_i(calc_en_q_i),
        .data_o(data_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*WI-1:0] got, input logic [N*WI-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [N*WI-1:0] rep(input byte b);
        return {N{b}};
    endfunction

    function automatic logic [N*WI-1:0] mkvec(input int s);
        byte pat[4] = '{-128, -1, 0, 127};
        logic [N*WI-1:0] v;
        for (int i = 0; i < N; i++)
            v[i*WI +: WI] = ((s + i) % 8 < 4) ? pat[(s + i) % 8] : 8'(s * 37 + i * 11);
        return v;
    endfunction

    task automatic add(input logic [1:0] act, input logic mode, input logic [7:0] mult,
                       input logic [7:0] shift, input logic [7:0] add_v, input byte q, input byte exp);
        tbl.push_back('{act, mode, mult, shift, add_v, q, exp});
    endtask

    task automatic apply(input int r);
        activation_i    = tbl[r].act;
        requant_mode_i  = tbl[r].mode;
        requant_mult_i  = tbl[r].mult;
        requant_shift_i = tbl[r].shift;
        requant_add_i   = tbl[r].add;
        data_i          = rep(tbl[r].q);
    endtask

    // Rows first..first+cnt-1 go in back to back; each result is checked exactly 4 edges later
    task automatic stream(input string name, input int first, input int cnt);
        for (int k = 0; k < cnt + 4; k++) begin
            @(negedge clk);
            if (k >= 4) check($sformatf("%s[%0d]", name, first + k - 4), data_o, rep(tbl[first + k - 4].exp));
            if (k < cnt) apply(first + k);
        end
    endtask

    initial begin
        logic [N*WI-1:0] hist[$];
        logic [N*WI-1:0] vs[5];
        add(2'd0, 1'b1, 8'd0, 8'd60, 8'd5,  -128, -128);
        add(2'd3, 1'b0, 8'd1, 8'd2,  8'd0,  -7,   -7);
        add(2'd2, 1'b0, 8'd1, 8'd2,  8'd0,  -5,   0);
        add(2'd2, 1'b0, 8'd1, 8'd2,  8'd0,  7,    7);
        add(2'd2, 1'b0, 8'd1, 8'd2,  8'd0,  0,    0);
        add(2'd2, 1'b0, 8'd1, 8'd2,  8'd0,  -128, 0);
        add(2'd2, 1'b0, 8'd1, 8'd2,  8'd0,  127,  127);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  10,   125);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  0,    0);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  30,   -128);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  1,    78);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  -1,   53);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  -10,  -125);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  -128, -128);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  -3,   104);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  127,  -128);
        add(2'd1, 1'b1, 8'd1, 8'd2,  8'd5,  0,    5);
        add(2'd1, 1'b1, 8'd1, 8'd2,  8'd5,  -10,  0);
        add(2'd1, 1'b1, 8'd1, 8'd2,  8'd5,  10,   -126);
        add(2'd1, 1'b1, 8'd1, 8'd2,  8'd5,  -128, 0);
        add(2'd1, 1'b0, 8'd1, 8'd0,  8'd0,  1,    127);
        add(2'd1, 1'b0, 8'd0, 8'd0,  8'hfd, -1,   -3);
        add(2'd1, 1'b0, 8'd1, 8'd60, 8'd7,  10,   7);
        add(2'd1, 1'b0, 8'd1, 8'd48, 8'hfe, -128, -2);
        add(2'd1, 1'b0, 8'd3, 8'd3,  8'd0,  -1,   79);
        add(2'd1, 1'b0, 8'd1, 8'd3,  8'd0,  -10,  -62);
        add(2'd0, 1'b0, 8'd1, 8'd2,  8'd0,  -5,   -5);
        add(2'd1, 1'b0, 8'd1, 8'd2,  8'd0,  10,   125);
        add(2'd2, 1'b0, 8'd1, 8'd2,  8'd0,  -5,   0);

        data_i       = {$urandom, $urandom, $urandom, $urandom};
        activation_i = 2'($urandom_range(0, 3));
        #1 rst_ni = 1'b0;
        #2 check("reset_async", data_o, '0);
        repeat (2) @(negedge clk);
        check("reset_held", data_o, '0);
        activation_i = 2'd0;
        data_i       = rep(42);
        rst_ni       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_first_early", data_o, '0);
        @(negedge clk);
        check("reset_first_latency", data_o, rep(42));

        stream("ident", 0, 1);
        stream("ident3", 1, 1);
        stream("relu", 2, 5);
        for (int r = 7; r < 26; r++) stream("gelu", r, 1);
        stream("modeswitch", 26, 3);

        activation_i = 2'd0;
        for (int c = 0; c < 68; c++) begin
            @(negedge clk);
            if (c >= 4) check("ident_stream", data_o, hist[c - 4]);
            hist.push_back(c < 64 ? mkvec(c) : '0);
            data_i = hist[c];
        end

        for (int k = 0; k < 5; k++) vs[k] = mkvec(200 + k);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            data_i = vs[k];
        end
        @(negedge clk);
        check("stall_pre", data_o, vs[0]);
        calc_en_i   = 1'b0;
        calc_en_q_i = 1'b0;
        data_i      = mkvec(250);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_hold", data_o, vs[0]);
        end
        calc_en_i   = 1'b1;
        calc_en_q_i = 1'b1;
        data_i      = vs[4];
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_resume[%0d]", k), data_o, vs[k]);
        end

        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            data_i = mkvec(300 + k);
        end
        @(negedge clk);
        #2 rst_ni = 1'b0;
        #1 check("reset_mid_async", data_o, '0);
        @(negedge clk);
        check("reset_mid_held", data_o, '0);
        rst_ni = 1'b1;
        data_i = mkvec(400);
        repeat (3) @(negedge clk);
        check("reset_mid_early", data_o, '0);
        @(negedge clk);
        check("reset_mid_latency", data_o, mkvec(400));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
